// File: rtl/mem_access.sv
// MEM stage of the cqu_mips pipeline: registers the EX outputs, runs a req/ack
// data-memory transaction, extends load data and hands the write-back word to WB.
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic [7:0]  aluop_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] store_data_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic [4:0]  write_reg_in,
  output logic        data_req,
  output logic        data_we,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_ack,
  output logic [31:0] wb_data,
  output logic [4:0]  write_reg,
  output logic        reg_write_out,
  output logic        mem_stall,
  output logic        adel,
  output logic        ades,
  output logic        bus_err
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [7:0]       aluop_r;
  logic [31:0]      alu_result_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      store_data_r;
  logic             mem_read_r;
  logic             mem_write_r;
  logic             mem_to_reg_r;
  logic             reg_write_r;
  logic [4:0]       write_reg_r;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      rdata_r;
  logic             bus_err_r;

  logic             memop_s;
  logic             misalign_s;
  logic             bad_s;
  logic             req_s;
  logic             stall_s;
  logic             advance_s;
  logic [31:0]      load_src_s;

  function automatic logic [31:0] load_ext(input logic [7:0] op, input logic [1:0] ofs,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (ofs)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = ofs[1] ? word[31:16] : word[15:0];
    case (op)
      EXE_LB_OP:  load_ext = {{24{b[7]}}, b};
      EXE_LBU_OP: load_ext = {24'h000000, b};
      EXE_LH_OP:  load_ext = {{16{h[15]}}, h};
      EXE_LHU_OP: load_ext = {16'h0000, h};
      default:    load_ext = word;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [7:0] op, input logic [1:0] ofs);
    case (op)
      EXE_SB_OP: store_strb = 4'b0001 << ofs;
      EXE_SH_OP: store_strb = 4'b0011 << ofs;
      EXE_SW_OP: store_strb = 4'b1111;
      default:   store_strb = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_word(input logic [7:0] op, input logic [31:0] d);
    case (op)
      EXE_SB_OP: store_word = {4{d[7:0]}};
      EXE_SH_OP: store_word = {2{d[15:0]}};
      EXE_SW_OP: store_word = d;
      default:   store_word = 32'h0000_0000;
    endcase
  endfunction

  // Alignment check on the registered op.
  always_comb begin
    misalign_s = 1'b0;
    case (aluop_r)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misalign_s = mem_addr_r[0];
      EXE_LW_OP, EXE_SW_OP:             misalign_s = (mem_addr_r[1:0] != 2'b00);
      default:                          misalign_s = 1'b0;
    endcase
  end

  assign memop_s   = mem_read_r | mem_write_r;
  assign bad_s     = memop_s & misalign_s;
  assign req_s     = memop_s & ~misalign_s & ((state_r == ST_IDLE) | (state_r == ST_WAIT));
  // The ack releases the stall in its own cycle so a zero-wait access is free.
  assign stall_s   = req_s & ~data_ack;
  assign advance_s = ~stall & ~stall_s;
  assign load_src_s = (state_r == ST_DONE) ? rdata_r : data_rdata;

  assign data_req      = req_s;
  assign data_we       = req_s & mem_write_r;
  assign data_addr     = {mem_addr_r[31:2], 2'b00};
  assign data_wstrb    = mem_write_r ? store_strb(aluop_r, mem_addr_r[1:0]) : 4'b0000;
  assign data_wdata    = mem_write_r ? store_word(aluop_r, store_data_r) : 32'h0000_0000;
  assign wb_data       = mem_to_reg_r ? load_ext(aluop_r, mem_addr_r[1:0], load_src_s)
                                      : alu_result_r;
  assign write_reg     = write_reg_r;
  assign reg_write_out = reg_write_r & ~bad_s & ~bus_err_r;
  assign mem_stall     = stall_s;
  assign adel          = bad_s & mem_read_r;
  assign ades          = bad_s & mem_write_r;
  assign bus_err       = bus_err_r;

  // Stage input register: advances with the pipeline, reset loads a NOP.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      aluop_r      <= 8'h00;
      alu_result_r <= 32'h0000_0000;
      mem_addr_r   <= 32'h0000_0000;
      store_data_r <= 32'h0000_0000;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
      reg_write_r  <= 1'b0;
      write_reg_r  <= 5'd0;
    end else if (advance_s) begin
      aluop_r      <= aluop_in;
      alu_result_r <= alu_result_in;
      mem_addr_r   <= mem_addr_in;
      store_data_r <= store_data_in;
      mem_read_r   <= mem_read_in;
      mem_write_r  <= mem_write_in;
      mem_to_reg_r <= mem_to_reg_in;
      reg_write_r  <= reg_write_in;
      write_reg_r  <= write_reg_in;
    end else begin
      aluop_r      <= aluop_r;
      alu_result_r <= alu_result_r;
      mem_addr_r   <= mem_addr_r;
      store_data_r <= store_data_r;
      mem_read_r   <= mem_read_r;
      mem_write_r  <= mem_write_r;
      mem_to_reg_r <= mem_to_reg_r;
      reg_write_r  <= reg_write_r;
      write_reg_r  <= write_reg_r;
    end
  end

  // Transaction FSM. A completion that coincides with advance goes straight back to
  // IDLE, otherwise the next op would be mistaken for an already finished one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      rdata_r   <= 32'h0000_0000;
      bus_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && data_ack) begin
            rdata_r <= data_rdata;
            state_r <= advance_s ? ST_IDLE : ST_DONE;
          end else if (req_s) begin
            state_r <= ST_WAIT;
            cnt_r   <= CNT_W'(1);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (data_ack) begin
            rdata_r <= data_rdata;
            cnt_r   <= '0;
            state_r <= advance_s ? ST_IDLE : ST_DONE;
          end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            bus_err_r <= 1'b1;
            cnt_r     <= '0;
            state_r   <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (advance_s) begin
            state_r   <= ST_IDLE;
            bus_err_r <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= '0;
          bus_err_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed ops push expectations, a monitor checks
// each op as it leaves the stage; a small responder plays the data memory.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  aluop_in = 8'h00;
  logic [31:0] alu_result_in = 32'h0;
  logic [31:0] mem_addr_in = 32'h0;
  logic [31:0] store_data_in = 32'h0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        mem_to_reg_in = 1'b0;
  logic        reg_write_in = 1'b0;
  logic [4:0]  write_reg_in = 5'd0;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata = 32'h0;
  logic        data_ack = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  write_reg;
  logic        reg_write_out;
  logic        mem_stall;
  logic        adel;
  logic        ades;
  logic        bus_err;

  typedef struct {
    logic [7:0] aluop; logic [31:0] alu; logic [31:0] addr; logic [31:0] sd;
    logic rd; logic wr; logic m2r; logic rw; logic [4:0] tag;
    int waits; logic [31:0] rdata;
    logic [31:0] e_wb; logic c_wb; logic e_rw; logic e_adel; logic e_ades; logic e_berr;
    logic e_we; logic c_bus; logic [31:0] e_addr; logic [3:0] e_strb; logic [31:0] e_wdata;
    int e_reqs; int e_stalls;
  } vec_t;

  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   rsp_waits = 0;
  logic [31:0] rsp_data = 32'h0;
  logic rsp_armed = 1'b0;
  logic force_ack = 1'b0;
  logic chk_zero = 1'b0;
  logic chk_hold = 1'b0;
  logic [31:0] hold_val = 32'h0;

  mem_access #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rstn(rstn), .stall(stall),
    .aluop_in(aluop_in), .alu_result_in(alu_result_in), .mem_addr_in(mem_addr_in),
    .store_data_in(store_data_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .write_reg_in(write_reg_in),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
    .wb_data(wb_data), .write_reg(write_reg), .reg_write_out(reg_write_out),
    .mem_stall(mem_stall), .adel(adel), .ades(ades), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Data memory: acks after rsp_waits request cycles of the armed op.
  initial begin : responder
    int seen;
    seen = 0;
    forever begin
      @(posedge clk);
      #2;
      data_ack = 1'b0;
      data_rdata = 32'h0;
      if (force_ack) begin
        data_ack = 1'b1;
      end else if (!rsp_armed) begin
        seen = 0;
      end else if (data_req === 1'b1) begin
        if (seen == rsp_waits) begin
          data_ack = 1'b1;
          data_rdata = rsp_data;
        end
        seen++;
      end
    end
  end

  // Monitor: counts request/stall cycles per op and checks each op as it leaves.
  initial begin : monitor
    vec_t e;
    int req_cnt, stall_cnt, age;
    req_cnt = 0; stall_cnt = 0; age = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        req_cnt = 0;
        stall_cnt = 0;
      end else begin
        if (data_req === 1'b1) req_cnt++;
        if (mem_stall === 1'b1) stall_cnt++;
      end
      if (chk_zero)
        chk("reset_zero", 128'({data_req, data_we, data_addr, data_wstrb, data_wdata, wb_data,
                                write_reg, reg_write_out, mem_stall, adel, ades, bus_err}),
            128'h0);
      if (chk_hold) chk("hold_wb", 128'(wb_data), 128'(hold_val));
      if (rstn && !stall && mem_stall === 1'b0 && write_reg !== 5'd0) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 128'(write_reg), 128'h0);
        end else begin
          e = sb.pop_front();
          chk("tag", 128'(write_reg), 128'(e.tag));
          if (e.c_wb) chk("wb_data", 128'(wb_data), 128'(e.e_wb));
          chk("reg_write_out", 128'(reg_write_out), 128'(e.e_rw));
          chk("adel", 128'(adel), 128'(e.e_adel));
          chk("ades", 128'(ades), 128'(e.e_ades));
          chk("bus_err", 128'(bus_err), 128'(e.e_berr));
          chk("data_we", 128'(data_we), 128'(e.e_we));
          if (e.c_bus) begin
            chk("data_addr", 128'(data_addr), 128'(e.e_addr));
            chk("data_wstrb", 128'(data_wstrb), 128'(e.e_strb));
            chk("data_wdata", 128'(data_wdata), 128'(e.e_wdata));
          end
          chk("req_cycles", 128'(req_cnt), 128'(e.e_reqs));
          chk("stall_cycles", 128'(stall_cnt), 128'(e.e_stalls));
        end
        req_cnt = 0;
        stall_cnt = 0;
        age = 0;
      end else if (sb.size() != 0) begin
        age++;
        if (age > 60) begin
          chk("retire_timeout", 128'(age), 128'h0);
          void'(sb.pop_front());
          age = 0;
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    aluop_in = v.aluop; alu_result_in = v.alu; mem_addr_in = v.addr; store_data_in = v.sd;
    mem_read_in = v.rd; mem_write_in = v.wr; mem_to_reg_in = v.m2r; reg_write_in = v.rw;
    write_reg_in = v.tag;
  endtask

  task automatic bubble();
    aluop_in = 8'h00; alu_result_in = 32'h0; mem_addr_in = 32'h0; store_data_in = 32'h0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0; reg_write_in = 1'b0;
    write_reg_in = 5'd0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
  endtask

  task automatic run(input vec_t v);
    sb.push_back(v);
    rsp_waits = v.waits; rsp_data = v.rdata; rsp_armed = 1'b1;
    @(posedge clk); #1; drive(v);
    @(posedge clk); #1; bubble();
    wait_drain();
    rsp_armed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    vec_t vt[12];
    vec_t vs, vr, vk;
    vt[0]  = '{8'hE3, 32'h100, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 0, 32'hDEADBEEF,
               32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 1, 0};
    vt[1]  = '{8'hE0, 32'h103, 32'h103, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 3, 32'h80FFFFFF,
               32'hFFFFFF80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 4, 3};
    vt[2]  = '{8'hE4, 32'h103, 32'h103, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 3, 32'h80FFFFFF,
               32'h00000080, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 4, 3};
    vt[3]  = '{8'hE1, 32'h102, 32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1, 32'h80011234,
               32'hFFFF8001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 2, 1};
    vt[4]  = '{8'hE5, 32'h100, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 0, 32'h8001F234,
               32'h0000F234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 1, 0};
    vt[5]  = '{8'hE9, 32'h22, 32'h22, 32'h1234ABCD, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 0, 32'h0,
               32'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 4'hC, 32'hABCDABCD, 1, 0};
    vt[6]  = '{8'hE8, 32'h41, 32'h41, 32'h000000A5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 2, 32'h0,
               32'h41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 4'h2, 32'hA5A5A5A5, 3, 2};
    vt[7]  = '{8'hEB, 32'h80, 32'h80, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 0, 32'h0,
               32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 4'hF, 32'hCAFEF00D, 1, 0};
    vt[8]  = '{8'hE3, 32'h101, 32'h101, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 0, 32'h0,
               32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 0};
    vt[9]  = '{8'hE9, 32'h23, 32'h23, 32'h0000BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 0, 32'h0,
               32'h23, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 0};
    vt[10] = '{8'h20, 32'h12345678, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 0, 32'h0,
               32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 0, 0};
    vt[11] = '{8'hE3, 32'h200, 32'h200, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 1000, 32'h0,
               32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 4'h0, 32'h0, 16, 16};
    vs     = '{8'hE3, 32'h300, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 0, 32'h0BADF00D,
               32'h0BADF00D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 4'h0, 32'h0, 1, 0};
    vk     = '{8'hE3, 32'h200, 32'h200, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd14, 1000, 32'h0,
               32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, 0};
    vr     = '{8'hE3, 32'h104, 32'h104, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd15, 1, 32'h55AA55AA,
               32'h55AA55AA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 4'h0, 32'h0, 2, 1};

    @(posedge clk); #1; chk_zero = 1'b1;
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1; chk_zero = 1'b0;

    for (int i = 0; i < 12; i++) run(vt[i]);

    // Ack arrives while the pipeline is stalled: one request, result held.
    sb.push_back(vs);
    rsp_waits = vs.waits; rsp_data = vs.rdata; rsp_armed = 1'b1;
    @(posedge clk); #1; drive(vs);
    @(posedge clk); #1; bubble(); stall = 1'b1; hold_val = 32'h0BADF00D; chk_hold = 1'b1;
    repeat (3) @(posedge clk);
    @(posedge clk); #1; stall = 1'b0; chk_hold = 1'b0;
    wait_drain();
    rsp_armed = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while waiting on the bus, then a stray ack with nothing outstanding.
    rsp_waits = vk.waits; rsp_armed = 1'b1;
    @(posedge clk); #1; drive(vk);
    @(posedge clk); #1; bubble();
    repeat (2) @(posedge clk);
    #1; rstn = 1'b0;
    @(posedge clk); #1; chk_zero = 1'b1; rsp_armed = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1; force_ack = 1'b1;
    @(posedge clk); #1; force_ack = 1'b0;
    @(posedge clk); #1; chk_zero = 1'b0;

    run(vr);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
